// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// A single one-bit full-adder cell is time-shared across WIDTH clocks, LSB first,
// with a registered carry. Operands enter through a valid/ready handshake and the
// result {cout,sum} = a + b + cin leaves through a second valid/ready handshake.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin        operands and initial carry, sampled on the accept edge
//   out_valid/ready  result handshake (out_valid high only in DONE)
//   sum, cout        registered result, meaningful while out_valid is high
//   busy             high in RUN or DONE
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept_c;
    logic             last_c;
    logic             fa_s_c;
    logic             fa_c_c;
    logic [WIDTH-1:0] sum_shift_c;

    // Full-adder cell on the current LSBs and the registered carry
    always_comb begin
        fa_s_c = sa[0] ^ sb[0] ^ carry;
        fa_c_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        // New bit enters at the MSB; after WIDTH shifts bit i lands at sum[i]
        sum_shift_c = (sum >> 1) | (WIDTH'(fa_s_c) << (WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake/status flags registered from the next state so outputs are flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Serial datapath: operand shift registers, carry, bit counter, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept_c) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= fa_c_c;
            cnt   <= cnt + CW'(1);
            sum   <= sum_shift_c;
            if (last_c) begin
                cout <= fa_c_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed scenarios plus randomized operand pairs
// checked against a + b + cin, on a WIDTH=8 instance and a WIDTH=1 instance.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic [0:0]   sum1;
    logic         cout1;
    logic         busy1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold = DONE cycles with out_ready low before draining
    // (hold 0 keeps out_ready high so the result drains in the first DONE cycle).
    // noise scribbles in_valid/a/b/cin while the block is busy.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input int hold, input bit noise);
        logic [W:0] exp;
        int         w;
        int         lat;
        exp = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(icin);
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        cin       = icin;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            if (noise) begin
                in_valid = 1'($urandom);
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(W));
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(exp[W-1:0]));
            check("hold_cout", 32'(cout), 32'(exp[W]));
            @(posedge clk);
            #1;
            if (noise) begin
                in_valid = 1'($urandom);
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("done_valid", 32'(out_valid), 32'd1);
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  seen;

        // Reset defaults
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst1_in_ready", 32'(in_ready1), 32'd1);

        // Carry ripple and mixed pattern
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h5A, 8'h33, 1'b1, 0, 1'b0);

        // Backpressure
        run_op(8'h80, 8'h80, 1'b1, 5, 1'b0);

        // Ignore in_valid while busy
        run_op(8'hC3, 8'h7E, 1'b0, 3, 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_second_result", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        run_op(8'h0F, 8'hF0, 1'b1, 0, 1'b0);

        // Randomized back-to-back traffic with random backpressure
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), bit'(i % 2));
        end

        // WIDTH=1 instance: one RUN cycle
        @(negedge clk);
        in_valid1  = 1'b1;
        a1         = 1'b1;
        b1         = 1'b1;
        cin1       = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("w1_run_valid", 32'(out_valid1), 32'd0);
        check("w1_run_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check("w1_valid", 32'(out_valid1), 32'd1);
        check("w1_sum", 32'(sum1), 32'd1);
        check("w1_cout", 32'(cout1), 32'd1);
        @(negedge clk);
        check("w1_post_in_ready", 32'(in_ready1), 32'd1);
        check("w1_post_valid", 32'(out_valid1), 32'd0);

        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b0;
        cin1      = 1'b0;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w1b_valid", 32'(out_valid1), 32'd1);
        check("w1b_sum", 32'(sum1), 32'd1);
        check("w1b_cout", 32'(cout1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
